// File: rtl/signed_accum_ctrl_if.sv
// Handshake bundle for signed_accum_ctrl: job request, operand stream and result stream.
interface signed_accum_ctrl_if #(
    parameter int W  = 4,
    parameter int CW = 3
);
    logic          start;
    logic [CW-1:0] count;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_overflow;
    logic          busy;

    modport master (
        output start, count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, busy
    );

    modport slave (
        input  start, count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, busy
    );
endinterface

// File: rtl/signed_accum_ctrl.sv
// Accumulates count+1 signed operands into a wrapping W-bit sum with a sticky
// signed-overflow flag, then presents the result until it is accepted.
module signed_accum_ctrl #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic clk,
    input  logic rst_n,
    signed_accum_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  acc_reg, acc_next;
    logic          ovf_reg, ovf_next;
    logic [CW-1:0] remaining_reg, remaining_next;
    logic [W-1:0]  sum_reg, sum_next;
    logic          out_ovf_reg, out_ovf_next;
    logic [W-1:0]  add_result;
    logic          add_ovf;

    // Signed overflow: both addends share a sign that the truncated sum does not.
    assign add_result = acc_reg + bus.in_data;
    assign add_ovf    = (acc_reg[W-1] == bus.in_data[W-1]) &&
                        (add_result[W-1] != acc_reg[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            remaining_reg <= '0;
            sum_reg       <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            ovf_reg       <= ovf_next;
            remaining_reg <= remaining_next;
            sum_reg       <= sum_next;
            out_ovf_reg   <= out_ovf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        ovf_next       = ovf_reg;
        remaining_next = remaining_reg;
        sum_next       = sum_reg;
        out_ovf_next   = out_ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next     = ACCUM;
                    remaining_next = bus.count;
                    acc_next       = '0;
                    ovf_next       = 1'b0;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_next = add_result;
                    ovf_next = ovf_reg | add_ovf;
                    // Result registers load on the last operand so DONE follows with no gap.
                    if (remaining_reg == '0) begin
                        state_next   = DONE;
                        sum_next     = add_result;
                        out_ovf_next = ovf_reg | add_ovf;
                    end else begin
                        remaining_next = remaining_reg - 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready     = (state_reg == ACCUM);
    assign bus.out_valid    = (state_reg == DONE);
    assign bus.busy         = (state_reg != IDLE);
    assign bus.out_sum      = sum_reg;
    assign bus.out_overflow = out_ovf_reg;
endmodule

// File: tb/tb_signed_accum_ctrl.sv
// Scenario-driven bench for signed_accum_ctrl with a queue of expected results.
module tb_signed_accum_ctrl;
    localparam int W  = 4;
    localparam int CW = 3;

    typedef struct {
        logic [W-1:0] sum;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hs_count;
    int   cyc;
    int   ops[16];
    exp_t exp_q[$];

    signed_accum_ctrl_if #(.W(W), .CW(CW)) bus ();

    signed_accum_ctrl #(.W(W), .CW(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) hs_count <= hs_count + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Starts a job and feeds ops[0..count]; pushes the independently modelled result.
    task automatic feed(input logic [CW-1:0] cnt, input int max_gap, input bit poke_start);
        int   n;
        int   a;
        int   t;
        int   gap;
        bit   ov;
        logic signed [W-1:0] tw;
        exp_t e;
        n  = int'(cnt) + 1;
        a  = 0;
        ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = a + ops[i];
            if (t > 7 || t < -8) ov = 1'b1;
            tw = t[W-1:0];
            a  = int'(tw);
        end
        tw    = a[W-1:0];
        e.sum = tw;
        e.ovf = ov;
        exp_q.push_back(e);

        bus.start = 1'b1;
        bus.count = cnt;
        @(posedge clk); #1;
        bus.start = poke_start;
        bus.count = ~cnt;
        for (int i = 0; i < n; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 4'(ops[(i + 5) % 16]);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(ops[i]);
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 10) begin
                @(posedge clk); #1;
                t++;
            end
            if (bus.in_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL feed_in_ready: operand %0d got in_ready=%b, required 1", i, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, watches stability for `stall` cycles, then accepts.
    task automatic take(input int stall, output logic [W-1:0] s, output logic o,
                        output bit seen, output bit stable, output bit gone);
        int t;
        t      = 0;
        stable = 1'b1;
        while (bus.out_valid !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        seen = (bus.out_valid === 1'b1);
        s    = bus.out_sum;
        o    = bus.out_overflow;
        repeat (stall) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== s || bus.out_overflow !== o) stable = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        gone = (bus.out_valid === 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_sum, bus.out_overflow} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b sum=%h ovf=%b, required all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_sum, bus.out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] s; logic o; bit seen, stable, gone; exp_t e;
        ops[0] = 2; ops[1] = 3; ops[2] = 1;
        feed(3'd2, 0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got out_valid=%b one cycle after last handshake, required 1", bus.out_valid);
        end
        take(0, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf || s !== 4'd6) begin
            errors++;
            $display("FAIL basic_result: got seen=%b sum=%0d ovf=%b, required sum=%0d ovf=%b",
                     seen, $signed(s), o, $signed(e.sum), e.ovf);
        end
        checks++;
        if (!gone || bus.out_sum !== e.sum) begin
            errors++;
            $display("FAIL basic_idle_hold: got out_valid_dropped=%b sum=%h, required dropped=1 sum=%h",
                     gone, bus.out_sum, e.sum);
        end
        $display("basic job: sum=%0d ovf=%b", $signed(s), o);
    endtask

    task automatic test_overflow;
        logic [W-1:0] s; logic o; bit seen, stable, gone; exp_t e;
        ops[0] = 7; ops[1] = 1;
        feed(3'd1, 0, 1'b0);
        take(0, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf || s !== 4'b1000 || o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_7p1: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        ops[0] = 7; ops[1] = 1; ops[2] = -1;
        feed(3'd2, 0, 1'b0);
        take(0, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf || s !== 4'd7 || o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        $display("overflow jobs: last sum=%0d ovf=%b", $signed(s), o);
    endtask

    task automatic test_negative;
        logic [W-1:0] s; logic o; bit seen, stable, gone; exp_t e;
        ops[0] = -8; ops[1] = -1;
        feed(3'd1, 0, 1'b0);
        take(0, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf || s !== 4'd7 || o !== 1'b1) begin
            errors++;
            $display("FAIL neg_m8m1: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        ops[0] = -4; ops[1] = -4;
        feed(3'd1, 0, 1'b0);
        take(0, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf || s !== 4'b1000 || o !== 1'b0) begin
            errors++;
            $display("FAIL neg_m4m4: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        $display("negative jobs: last sum=%0d ovf=%b", $signed(s), o);
    endtask

    task automatic test_stall;
        logic [W-1:0] s; logic o; bit seen, stable, gone; exp_t e;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) ops[i] = int'($urandom_range(15, 0)) - 8;
            feed(3'd3, 3, 1'b1);
            take(5, s, o, seen, stable, gone);
            bus.start = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (!seen || s !== e.sum || o !== e.ovf) begin
                errors++;
                $display("FAIL stall_result: round %0d got sum=%h ovf=%b, required sum=%h ovf=%b",
                         r, s, o, e.sum, e.ovf);
            end
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL stall_stable: round %0d got stable=%b, required 1", r, stable);
            end
            checks++;
            if (!gone || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL stall_start_ignored: round %0d got dropped=%b busy=%b, required 1 and 0",
                         r, gone, bus.busy);
            end
            $display("stall job %0d: ops %0d %0d %0d %0d sum=%0d ovf=%b",
                     r, ops[0], ops[1], ops[2], ops[3], $signed(s), o);
        end
    endtask

    task automatic test_full_count;
        logic [W-1:0] s; logic o; bit seen, stable, gone; exp_t e; int h0, c0;
        for (int i = 0; i < 8; i++) ops[i] = 1;
        h0 = hs_count;
        c0 = cyc;
        feed(3'd7, 0, 1'b0);
        checks++;
        if (cyc - c0 != 9) begin
            errors++;
            $display("FAIL full_throughput: got %0d cycles for start+8 operands, required 9", cyc - c0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_done: got in_ready=%b in DONE, required 0", bus.in_ready);
        end
        take(2, s, o, seen, stable, gone);
        bus.in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (hs_count - h0 != 8) begin
            errors++;
            $display("FAIL full_handshakes: got %0d handshakes, required 8", hs_count - h0);
        end
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf || s !== 4'b1000 || o !== 1'b1) begin
            errors++;
            $display("FAIL full_result: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        ops[0] = -3;
        feed(3'd0, 0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got out_valid=%b, required 1", bus.out_valid);
        end
        take(0, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf || s !== 4'hD || o !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        $display("full/single jobs: last sum=%0d ovf=%b", $signed(s), o);
    endtask

    task automatic test_async_reset;
        logic [W-1:0] s; logic o; bit seen, stable, gone; exp_t e; bit vld_seen;
        bus.start = 1'b1;
        bus.count = 3'd3;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_sum, bus.out_overflow} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_outputs: got rdy=%b vld=%b busy=%b sum=%h ovf=%b, required all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_sum, bus.out_overflow);
        end
        bus.start = 1'b1;
        bus.count = 3'd0;
        vld_seen  = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) vld_seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (vld_seen || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_abort: got activity_in_reset=%b busy_after_first_edge=%b, required 0 and 1",
                     vld_seen, bus.busy);
        end
        e.sum = 4'hD;
        e.ovf = 1'b0;
        exp_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hD;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        take(0, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf) begin
            errors++;
            $display("FAIL async_reset_next_job: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        ops[0] = 5; ops[1] = -2; ops[2] = 4;
        feed(3'd2, 1, 1'b0);
        take(1, s, o, seen, stable, gone);
        e = exp_q.pop_front();
        checks++;
        if (!seen || s !== e.sum || o !== e.ovf) begin
            errors++;
            $display("FAIL async_reset_follow_job: got sum=%h ovf=%b, required sum=%h ovf=%b", s, o, e.sum, e.ovf);
        end
        $display("after async reset: sum=%0d ovf=%b", $signed(s), o);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        hs_count      = 0;
        cyc           = 0;
        bus.start     = 1'b0;
        bus.count     = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) ops[i] = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_negative();
        test_stall();
        test_full_count();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/signed_accum_ctrl.md
SIGNED_ACCUM_CTRL -- requirements
Module: signed_accum_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning the operand and accumulator width in bits, two's complement.
REQ-002 The block SHALL have parameter CW, default 3, meaning the width of the operand-count field, allowing up to 2**CW operands per job.
REQ-003 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 start  input  1  Job request; sampled only in IDLE.
REQ-006 count  input  CW  Number of operands minus 1; sampled together with start.
REQ-007 in_valid  input  1  Operand valid.
REQ-008 in_data  input  W  Signed operand.
REQ-009 in_ready  output  1  Operand accept.
REQ-010 out_valid  output  1  Result valid.
REQ-011 out_ready  input  1  Result accept.
REQ-012 out_sum  output  W  Signed accumulated sum, wrapped modulo 2**W.
REQ-013 out_overflow  output  1  Sticky signed-overflow flag for the job.
REQ-014 busy  output  1  High in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 IDLE: in_ready=0 and out_valid=0; on start=1 the block SHALL go to ACCUM, load remaining=count, clear acc to 0 and clear ovf to 0.
REQ-017 start SHALL be ignored in ACCUM and DONE, including a start in the same cycle as the DONE output handshake.
REQ-018 ACCUM: in_ready SHALL be 1, driven from state only, with no combinational path from in_valid.
REQ-019 An operand handshake (in_valid & in_ready) SHALL update acc <= acc + in_data, truncated to W bits.
REQ-020 On each operand handshake, ovf SHALL be set when the two addend signs are equal and the sum sign differs; once set, ovf SHALL stay set until the next job start.
REQ-021 ovf SHALL remain 1 even when later operands bring the wrapped sum back into range.
REQ-022 On the handshake with remaining==0 the block SHALL go to DONE; otherwise remaining SHALL decrement by 1.
REQ-023 Cycles in ACCUM with in_valid=0 SHALL leave all state unchanged; there is no timeout.
REQ-024 DONE: out_valid SHALL be 1, and out_sum=acc and out_overflow=ovf SHALL be registered values held stable until out_ready=1.
REQ-025 On out_valid & out_ready the block SHALL return to IDLE, with out_valid=0 in the next cycle.
REQ-026 Latency: out_valid SHALL rise in the cycle after the last operand handshake, and no extra cycles SHALL be inserted.
REQ-027 count=0 SHALL mean a one-operand job; count=2**CW-1 SHALL mean a 2**CW-operand job, and remaining SHALL never wrap.
REQ-028 Throughput SHALL be one operand per cycle while in_valid is held high.
REQ-029 out_sum and out_overflow SHALL retain their last value in IDLE and ACCUM; only out_valid qualifies them.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, acc=0, ovf=0, remaining=0, in_ready=0, out_valid=0, out_sum=0, out_overflow=0 and busy=0, regardless of clk.
REQ-031 Reset asserted mid-job (ACCUM or DONE) SHALL abort the job with no result output.
REQ-032 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-033 W=4: start, count=2, operands 2,3,1 back-to-back -> out_valid 1 cycle after the 3rd handshake, out_sum=6, out_overflow=0.
REQ-034 count=1, operands 7,1 -> out_sum=-8 (4'b1000), out_overflow=1; a follow-up job with count=2, operands 7,1,-1 -> out_sum=7, out_overflow=1 (sticky).
REQ-035 count=1, operands -8,-1 -> out_sum=7, out_overflow=1; operands -4,-4 -> out_sum=-8, out_overflow=0.
REQ-036 count=3 with in_valid gaps of 0-3 cycles and out_ready held low for 5 cycles -> sum correct, out_sum/out_overflow stable while stalled, start pulses during the job ignored.
REQ-037 count=7 (8 operands of 1) -> out_sum=-8, out_overflow=1, exactly 8 handshakes accepted; count=0, operand -3 -> out_sum=-3, out_overflow=0.
REQ-038 rst_n pulsed low mid-ACCUM, asynchronous to clk -> outputs at reset values immediately, no out_valid, next job result correct.
